// File: rtl/keypad_pkg.sv
// Shared types, key codes and key-to-matrix mapping for the 4x3 keypad emulator.
package keypad_pkg;

  localparam int ROW_W = 4;
  localparam int COL_W = 3;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_MAX  = 4'd11;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP,
    ST_BOUNCE_IN,
    ST_BOUNCE_OUT
  } state_t;

  // Phone layout: 1-2-3 on row 0 down to *-0-# on row 3.
  function automatic logic [1:0] key_row(input logic [3:0] code);
    case (code)
      4'd1, 4'd2, 4'd3: key_row = 2'd0;
      4'd4, 4'd5, 4'd6: key_row = 2'd1;
      4'd7, 4'd8, 4'd9: key_row = 2'd2;
      default:          key_row = 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] code);
    case (code)
      4'd1, 4'd4, 4'd7, KEY_STAR: key_col = 2'd0;
      4'd2, 4'd5, 4'd8, 4'd0:     key_col = 2'd1;
      4'd3, 4'd6, 4'd9, KEY_HASH: key_col = 2'd2;
      default:                    key_col = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) that advances only while enabled.
module keypad_lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic feedback;

  assign feedback = state[0] ^ state[2] ^ state[3] ^ state[5];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= seed;
    end else if (enable) begin
      state <= {feedback, state[15:1]};
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// Keypad emulator: presses one key per handshake by answering row strobes on the column lines.
// Optional contact bounce around each press is enabled with the KEYPAD_BOUNCE_EN macro.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES   = 2_000_000,
  parameter int GAP_CYCLES    = 2_000_000,
  parameter int BOUNCE_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_ready,
  input  logic [ROW_W-1:0] keyboard_rows,
  output logic [COL_W-1:0] keyboard_cols,
  output logic             busy,
  output logic             key_done,
  output logic             key_err
);

  localparam int MAX_HG   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_LOAD = (MAX_HG > BOUNCE_CYCLES) ? MAX_HG : BOUNCE_CYCLES;
  localparam int CNT_W    = $clog2(MAX_LOAD + 1);

  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO     = CNT_W'(2);

`ifdef KEYPAD_BOUNCE_EN
  localparam state_t           FIRST_ST   = ST_BOUNCE_IN;
  localparam logic [CNT_W-1:0] FIRST_LOAD = BOUNCE_LOAD;
`else
  localparam state_t           FIRST_ST   = ST_PRESS;
  localparam logic [CNT_W-1:0] FIRST_LOAD = HOLD_LOAD;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       row_sel;
  logic [1:0]       col_sel;
  logic             contact;
  logic [COL_W-1:0] col_onehot;

`ifdef KEYPAD_BOUNCE_EN
  logic [15:0] lfsr;
  logic        bounce_active;

  assign bounce_active = (state == ST_BOUNCE_IN) || (state == ST_BOUNCE_OUT);

  keypad_lfsr16 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .enable (bounce_active),
    .seed   (LFSR_SEED),
    .state  (lfsr)
  );
`endif

  // NOTE: every state and output register below uses <=, so all of them update from the
  // same pre-edge values; a blocking = here would let later statements see new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      row_sel   <= '0;
      col_sel   <= '0;
      key_ready <= 1'b1;
      busy      <= 1'b0;
      key_done  <= 1'b0;
      key_err   <= 1'b0;
    end else begin
      key_done <= 1'b0;
      key_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (key_valid) begin
            row_sel <= key_row(key_code);
            col_sel <= key_col(key_code);
            if (key_code > KEY_MAX) begin
              key_err <= 1'b1;
            end else begin
              state     <= FIRST_ST;
              cnt       <= FIRST_LOAD;
              key_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end

`ifdef KEYPAD_BOUNCE_EN
        ST_BOUNCE_IN: begin
          if (cnt == CNT_ONE) begin
            state <= ST_PRESS;
            cnt   <= HOLD_LOAD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ST_PRESS: begin
          if (cnt == CNT_ONE) begin
            state <= ST_BOUNCE_OUT;
            cnt   <= BOUNCE_LOAD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ST_BOUNCE_OUT: begin
          if (cnt == CNT_ONE) begin
            state    <= ST_GAP;
            cnt      <= GAP_LOAD;
            key_done <= (GAP_CYCLES == 1);
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
`else
        ST_PRESS: begin
          if (cnt == CNT_ONE) begin
            state    <= ST_GAP;
            cnt      <= GAP_LOAD;
            key_done <= (GAP_CYCLES == 1);
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
`endif

        // key_done is registered, so it is raised on the edge entering the final GAP cycle.
        ST_GAP: begin
          if (cnt == CNT_ONE) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            key_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt      <= cnt - CNT_ONE;
            key_done <= (cnt == CNT_TWO);
          end
        end

        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          key_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: contact gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    contact = 1'b0;
    case (state)
      ST_PRESS: contact = 1'b1;
`ifdef KEYPAD_BOUNCE_EN
      ST_BOUNCE_IN, ST_BOUNCE_OUT: contact = lfsr[0];
`endif
      default: contact = 1'b0;
    endcase
  end

  // Combinational from the row strobes so the scanner sees the column in the same cycle.
  assign col_onehot    = COL_W'(3'b001 << col_sel);
  assign keyboard_cols = (contact && keyboard_rows[row_sel]) ? col_onehot : '0;

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Synthesizable responder for the 4x3 matrix keypad interface: takes a key code over a valid/ready handshake and drives `keyboard_cols` in response to the scanned one-hot `keyboard_rows`, exactly as a physical key closure would. It sits on the far side of the keypad pins, replacing the physical keypad for board self-test and hardware-in-the-loop replay of BinGo number entry. Press duration and inter-key gap are programmable so presses pass the scanner's debounce window.

## Interface
- `HOLD_CYCLES`, default 2_000_000: cycles the contact is closed; must be ≥ 1 and exceed the scanner debounce window.
- `GAP_CYCLES`, default 2_000_000: released cycles after each press before the next key is accepted; ≥ 1.
- `BOUNCE_CYCLES`, default 4096: bounce interval length; used only with `KEYPAD_BOUNCE_EN`.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `key_valid` in 1: key request valid.
- `key_code` in 4: key to press. 0..9 digits, 10 = `*`, 11 = `#` (start).
- `key_ready` out 1: high in IDLE only.
- `keyboard_rows` in 4: row strobes from the scanner, bit i = row i.
- `keyboard_cols` out 3: column returns, bit j = column j.
- `busy` out 1: state ≠ IDLE.
- `key_done` out 1: one-cycle pulse on the last GAP cycle.
- `key_err` out 1: one-cycle pulse when `key_code` 12..15 is accepted.

## Operation
- Key map (phone layout): code k in 1..9 → row (k-1)/3, col (k-1)%3. Code 10 → row 3, col 0. Code 0 → row 3, col 1. Code 11 → row 3, col 2.
- FSM states:
  - IDLE: `key_ready`=1. On `key_valid`, latch the row/col of `key_code`.
    - Valid code → PRESS.
    - Code 12..15 → pulse `key_err`, stay IDLE. No press occurs; still counts as accepted.
  - PRESS: contact closed for HOLD_CYCLES cycles → GAP.
  - GAP: contact open for GAP_CYCLES cycles. `key_done` pulses on the last cycle → IDLE.
- Contact output: `keyboard_cols` = one-hot(latched col) when contact is closed AND `keyboard_rows[latched row]`=1; otherwise 3'b000.
  - This path is combinational from `keyboard_rows`, gated by registered state, so the scanner sees the column in the same cycle the row is strobed.
  - Non-one-hot rows: the column is driven whenever the latched row bit is set.
- Inputs are ignored while `key_ready`=0; no request queueing.
- Single down-counter, width $clog2(max(HOLD_CYCLES, GAP_CYCLES, BOUNCE_CYCLES)+1). It is loaded on each state entry and the state is left when it reaches 1.

## Timing
- Reset values:
  - state IDLE, counter 0, `keyboard_cols` 0, `key_ready` 1, `busy` 0, `key_done` 0, `key_err` 0.
  - Latched row/col 0. LFSR = 16'hACE1.
- Acceptance at rising edge T (`key_valid` & `key_ready`):
  - `key_ready`=0 and contact closed from cycle T+1.
  - Contact stays closed for exactly HOLD_CYCLES cycles, then GAP for exactly GAP_CYCLES cycles.
  - `key_done` pulses in cycle T+HOLD_CYCLES+GAP_CYCLES.
  - `key_ready`=1 again in cycle T+HOLD_CYCLES+GAP_CYCLES+1.
- Invalid code accepted at T: `key_err`=1 in cycle T+1. `key_ready` stays 1; `busy` stays 0.
- `rst` mid-operation: next cycle is IDLE with `keyboard_cols`=0. The press is aborted and no `key_done` is issued.
- A `key_valid` held high continuously re-issues the same key after each `key_done`.

## Configuration
- `KEYPAD_BOUNCE_EN` defined:
  - PRESS is split into BOUNCE_IN (BOUNCE_CYCLES), HOLD (HOLD_CYCLES), BOUNCE_OUT (BOUNCE_CYCLES).
  - In the bounce states the contact closure equals LFSR bit 0. The 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) advances every bounce cycle.
  - Total acceptance-to-ready time grows by 2·BOUNCE_CYCLES.
- `KEYPAD_BOUNCE_EN` undefined: no bounce states, no LFSR; clean closure as above.

## Structure
- Package `keypad_pkg`:
  - state encoding.
  - constants KEY_STAR=4'd10, KEY_HASH=4'd11, KEY_MAX=4'd11.
  - key→row and key→col functions.
  - row/col widths 4/3.
- One sub-module, `keypad_lfsr16` (enable, seed, 16-bit state), instantiated only under `KEYPAD_BOUNCE_EN`.

## Test plan
Bench parameters: HOLD_CYCLES=8, GAP_CYCLES=4, BOUNCE_CYCLES=4. A rotating one-hot row model drives `keyboard_rows`.

- Key 5 accepted at T → `keyboard_cols`=3'b010 only while rows=4'b0010, during T+1..T+8. `key_done` at T+12; `key_ready` at T+13.
- Key 11, then key 0 back-to-back with `key_valid` held:
  - First press: cols 3'b100 on row 3.
  - Second press: cols 3'b010 on row 3, starting exactly one cycle after `key_ready` rises.
- Key 14 → `key_err` pulse at T+1, `keyboard_cols` stays 0, `key_ready` stays 1.
- `rst` asserted at T+5 during a key 1 press → cols 0 and `key_ready`=1 next cycle, no `key_done`.
- rows=4'b1111 with key 10 → cols 3'b001 for all 8 PRESS cycles.
- With `KEYPAD_BOUNCE_EN`, key 7: cols toggle per the LFSR from seed 16'hACE1 for 4 cycles, solid 3'b001 on row 2 for 8 cycles, bounce for 4 cycles. `key_ready` returns at T+21.
